// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
// State encoding, Booth pair codes and ALU select values.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Pairs 01 and 10 change A; 00 and 11 leave it alone.
    function automatic logic booth_acts(input logic [1:0] pair);
        return (pair == BOOTH_ADD) || (pair == BOOTH_SUB);
    endfunction

endpackage

// File: rtl/alu_addSub.sv
// Shared add/subtract ALU used by the Booth iteration.
// addSub selects a-b when high, a+b when low.
module alu_addSub
    import booth_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             addSub,
    output logic [WIDTH-1:0] result
);

    // Single adder with operand inversion for subtraction.
    always_comb begin
        result = '0;
        if (addSub == ALU_SUB) begin
            result = a + ~b + WIDTH'(1);
        end else begin
            result = a + b;
        end
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential radix-2 Booth multiplier controller.
// One multiplier bit per EVAL/SHIFT pair; 2*DATA_WIDTH product.
module booth_mult_ctrl
    import booth_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   multiplicand,
    input  logic [DATA_WIDTH-1:0]   multiplier,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int AW = DATA_WIDTH + 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_t                state;
    logic [AW-1:0]         a_reg;
    logic [AW-1:0]         m_reg;
    logic [DATA_WIDTH-1:0] q_reg;
    logic                  q_1;
    logic [CW-1:0]         cnt;
    logic [1:0]            pair;
    logic                  add_sub;
    logic [AW-1:0]         alu_res;

    assign pair = {q_reg[0], q_1};

    // ALU select: subtract only on an EVAL with pair 10.
    always_comb begin
        add_sub = ALU_ADD;
        if (state == EVAL && pair == BOOTH_SUB) begin
            add_sub = ALU_SUB;
        end
    end

    alu_addSub #(
        .WIDTH (AW)
    ) u_alu (
        .a      (a_reg),
        .b      (m_reg),
        .addSub (add_sub),
        .result (alu_res)
    );

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= '0;
                        q_reg <= multiplier;
                        q_1   <= 1'b0;
                        m_reg <= {multiplicand[DATA_WIDTH-1],
                                  multiplicand};
                        cnt   <= CW'(DATA_WIDTH);
                        busy  <= 1'b1;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (booth_acts(pair)) begin
                        a_reg <= alu_res;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    a_reg <= {a_reg[AW-1], a_reg[AW-1:1]};
                    q_reg <= {a_reg[0], q_reg[DATA_WIDTH-1:1]};
                    q_1   <= q_reg[0];
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        product <= {a_reg, q_reg[DATA_WIDTH-1:1]};
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= EVAL;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Scoreboard bench for booth_mult_ctrl.
// Expected products come from plain signed multiplication.
module tb_booth_mult_ctrl;

    localparam int DW  = 16;
    localparam int LAT = 2 * DW + 1;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [DW-1:0]   multiplicand;
    logic [DW-1:0]   multiplier;
    logic            busy;
    logic            done;
    logic [2*DW-1:0] product;

    int errors;
    int checks;
    int cyc;
    int done_cnt;
    int act_start;
    bit active;
    logic [2*DW-1:0] last_prod;
    logic [2*DW-1:0] exp_q[$];

    booth_mult_ctrl #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*DW-1:0] ref_mul(
        input logic [DW-1:0] m,
        input logic [DW-1:0] q
    );
        longint p;
        p = longint'($signed(m)) * longint'($signed(q));
        return p[2*DW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h",
                     name, cyc, act, req);
        end
    endtask

    // Monitor: timing of busy/done, product pops and holds.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            logic exp_busy;
            logic exp_done;
            exp_busy = active && cyc >= act_start + 1 &&
                       cyc <= act_start + LAT;
            exp_done = active && cyc == act_start + LAT;
            check("busy", 64'(busy), 64'(exp_busy));
            check("done", 64'(done), 64'(exp_done));
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(1), 64'(0));
                end else begin
                    last_prod = exp_q.pop_front();
                    check("product", 64'(product), 64'(last_prod));
                end
            end else begin
                check("product_hold", 64'(product), 64'(last_prod));
            end
            if (active && cyc >= act_start + LAT) active = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    task automatic issue(input logic [DW-1:0] m, input logic [DW-1:0] q);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        exp_q.push_back(ref_mul(m, q));
        act_start = cyc;
        active    = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = DW'($urandom);
        multiplier   = DW'($urandom);
    endtask

    task automatic wait_done;
        int c0;
        int n;
        c0 = done_cnt;
        n  = 0;
        while (done_cnt == c0 && n < LAT + 8) begin
            tick();
            n++;
        end
        if (done_cnt == c0) check("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic run(input logic [DW-1:0] m, input logic [DW-1:0] q);
        issue(m, q);
        wait_done();
    endtask

    initial begin
        int s;
        errors       = 0;
        checks       = 0;
        cyc          = 0;
        done_cnt     = 0;
        active       = 1'b0;
        act_start    = 0;
        last_prod    = '0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        rst_n        = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_product", 64'(product), 64'(0));
        rst_n = 1'b1;
        repeat (2) tick();

        run(16'd3, 16'd5);
        run(-16'sd7, 16'd6);
        run(16'd6, -16'sd7);
        run(16'h8000, 16'h8000);
        run(16'h7FFF, 16'h8000);
        repeat (3) tick();
        run(16'h0000, 16'h1234);

        // Starts while busy and during DONE are ignored.
        s = cyc;
        issue(16'd2, 16'd2);
        goto(s + 5);
        start = 1'b1;
        multiplicand = 16'd9;
        multiplier   = 16'd9;
        tick();
        start = 1'b0;
        goto(s + 33);
        start = 1'b1;
        tick();
        issue(16'd9, 16'd9);
        wait_done();
        check("done_pulses", 64'(done_cnt), 64'(8));

        // Asynchronous reset mid-run clears everything.
        s = cyc;
        issue(16'd5, 16'd5);
        goto(s + 10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_product", 64'(product), 64'(0));
        exp_q.delete();
        active    = 1'b0;
        last_prod = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run(16'd4, -16'sd4);

        for (int i = 0; i < 24; i++) begin
            logic [DW-1:0] m;
            logic [DW-1:0] q;
            m = DW'($urandom);
            q = DW'($urandom);
            if (i % 8 == 3) m = 16'h8000;
            if (i % 8 == 5) q = 16'h7FFF;
            repeat ($urandom_range(0, 3)) tick();
            run(m, q);
        end

        repeat (3) tick();
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
